// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: reset values of the
// stack and global pointers and the register indices that receive them.
// No logic, no latency, no flow control.
package Parametros;

    // Reset value of the stack pointer register (x2).
    localparam logic [31:0] STACK_ADDRESS = 32'h8001_0000;
    // Reset value of the global/data pointer register (x3).
    localparam logic [31:0] DATA_ADDRESS  = 32'h1000_0000;

    // Register indices that are preset out of reset.
    localparam int SPR = 2;
    localparam int GPR = 3;

endpackage

// File: rtl/regfile_mp_wr_merge.sv
// Read-side merge for one read port: stored value, optionally replaced by a same-cycle write.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure mux with no handshake.
// Ports: rd_addr/rd_stored in, wr_en/wr_addr/wr_data (flattened per write port) in, rd_dat out.
// Macro REGFILE_BYPASS_EN: when defined, a committed write to rd_addr is forwarded
// (highest-numbered write port wins); when undefined, rd_stored passes straight through.
module regfile_wr_merge #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_stored,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rd_dat
);

`ifdef REGFILE_BYPASS_EN
    // Walk ports in ascending order so a later port overrides an earlier one,
    // matching the commit priority of the register array. x0 is never forwarded.
    always_comb begin
        rd_dat = rd_stored;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr) && (rd_addr != '0)) begin
                rd_dat = wr_data[p*XLEN +: XLEN];
            end
        end
    end
`else
    assign rd_dat = rd_stored;

    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data, rd_addr};
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard and a debug display port.
// Latency: reads and display combinational; writes, reserves and flushes take effect at the next iCLK edge.
// Backpressure: none; every write, reserve and flush is accepted in the cycle it is presented.
// Ports: iCLK, iRST_N (async active-low); iWrEn/iWrAddr/iWrData (NWR write ports, flattened);
//        iRdAddr -> oRdData/oRdBusy (NRD read ports, flattened); iRsvEn/iRsvAddr reserve;
//        iFlush clears all busy bits; iDispSel -> oDisp (never forwarded).
// Macro REGFILE_BYPASS_EN: enables same-cycle write-to-read forwarding on the read ports.
module regfile_mp
    import Parametros::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic [NWR-1:0]      iWrEn,
    input  logic [NWR*AW-1:0]   iWrAddr,
    input  logic [NWR*XLEN-1:0] iWrData,
    input  logic [NRD*AW-1:0]   iRdAddr,
    output logic [NRD*XLEN-1:0] oRdData,
    output logic [NRD-1:0]      oRdBusy,
    input  logic                iRsvEn,
    input  logic [AW-1:0]       iRsvAddr,
    input  logic                iFlush,
    input  logic [AW-1:0]       iDispSel,
    output logic [XLEN-1:0]     oDisp
);

    // Pointer reset values fitted to XLEN: zero-extended when wider, truncated when narrower.
    localparam logic [XLEN-1:0] SP_RST = XLEN'(STACK_ADDRESS);
    localparam logic [XLEN-1:0] GP_RST = XLEN'(DATA_ADDRESS);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NWR-1:0]  wr_en_act;

    function automatic logic [XLEN-1:0] rst_val(input int idx);
        if (NREG > 3 && idx == SPR) return SP_RST;
        if (NREG > 3 && idx == GPR) return GP_RST;
        return '0;
    endfunction

    // Writes presented while reset is low are discarded; gating here also keeps
    // them out of the read forwarding path so reads show the reset contents.
    assign wr_en_act = iWrEn & {NWR{iRST_N}};

    // Ascending port order: port 1 overrides port 0 on an address collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_act[p] && (iWrAddr[p*AW +: AW] != '0)) begin
                regs_d[iWrAddr[p*AW +: AW]] = iWrData[p*XLEN +: XLEN];
            end
        end
    end

    // Scoreboard priority, lowest to highest: write clear, reserve set, flush.
    // x0 is forced clear last so neither a reserve nor anything else can mark it.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en_act[p]) begin
                busy_d[iWrAddr[p*AW +: AW]] = 1'b0;
            end
        end
        if (iRsvEn) begin
            busy_d[iRsvAddr] = 1'b1;
        end
        if (iFlush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= rst_val(i);
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Busy flags come straight from the registered scoreboard: a reserve or
    // flush in the current cycle is not visible until after the edge.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_wr_merge #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_merge (
            .rd_addr   (iRdAddr[k*AW +: AW]),
            .rd_stored (regs_q[iRdAddr[k*AW +: AW]]),
            .wr_en     (wr_en_act),
            .wr_addr   (iWrAddr),
            .wr_data   (iWrData),
            .rd_dat    (oRdData[k*XLEN +: XLEN])
        );
        assign oRdBusy[k] = busy_q[iRdAddr[k*AW +: AW]];
    end

    assign oDisp = regs_q[iDispSel];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, register width in bits.
REQ-002 Parameter NREG, default 32, register count (power of two, 2..64); AW = clog2(NREG).
REQ-003 Parameter NRD, default 2, read ports (1..4).
REQ-004 Parameter NWR, default 2, write ports (1..2).
REQ-005 Clock and reset: one clock, iCLK; reset iRST_N, asynchronous, active-low.
REQ-006 Write enables: iWrEn input NWR; one per write port.
REQ-007 Write addresses: iWrAddr input NWR*AW; flattened, port p at [p*AW +: AW].
REQ-008 Write data: iWrData input NWR*XLEN; flattened.
REQ-009 Read addresses: iRdAddr input NRD*AW; flattened.
REQ-010 Read data: oRdData output NRD*XLEN; combinational read data.
REQ-011 Read busy flags: oRdBusy output NRD; scoreboard busy flag of each read address.
REQ-012 Reserve request: iRsvEn input 1; reserve (mark busy) register iRsvAddr.
REQ-013 Reserve address: iRsvAddr input AW.
REQ-014 Scoreboard clear: iFlush input 1; synchronous clear of all busy bits.
REQ-015 Display port: iDispSel input AW, oDisp output XLEN; combinational view of the selected register, never bypassed.

Function
REQ-016 Register 0 SHALL read as zero, ignore writes and never be busy.
REQ-017 A write on port p SHALL update the register at the rising edge of iCLK when iWrEn[p] is set and the address is nonzero.
REQ-018 If both write ports target the same register in one cycle, port 1 SHALL win.
REQ-019 Reads SHALL be combinational, with zero latency, from the stored array (or bypassed, per REQ-031).
REQ-020 The scoreboard SHALL hold one busy bit per register, all 0 after reset.
REQ-021 iRsvEn with nonzero iRsvAddr SHALL set busy[iRsvAddr] at the next edge.
REQ-022 A committed write SHALL clear busy[addr] at the same edge.
REQ-023 If reserve and write hit the same register in the same cycle, the reserve SHALL win and the busy bit SHALL end at 1.
REQ-024 iFlush SHALL clear all busy bits at the next edge, with priority over iRsvEn; register contents SHALL be unaffected.
REQ-025 oRdBusy[k] SHALL equal busy[iRdAddr[k]] as registered, with no same-cycle bypass of reserve or clear.
REQ-026 Stack and global pointer values narrower or wider than XLEN SHALL be zero-extended or truncated to XLEN.

Reset
REQ-027 While iRST_N is low, all registers SHALL be 0 except x2 = STACK_ADDRESS and x3 = DATA_ADDRESS (from Parametros), provided NREG > 3.
REQ-028 While iRST_N is low, all busy bits SHALL be 0; oRdData and oDisp SHALL reflect the reset contents.
REQ-029 Reset asserted mid-operation SHALL override every pending write and reserve in that cycle.
REQ-030 Reset release SHALL be synchronous to iCLK; the first write is accepted at the first edge with iRST_N high.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN defined: a read whose address matches a same-cycle committed write SHALL return that write data, following the REQ-018 priority; zero register excluded.
REQ-032 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge stored value.

Structure
REQ-033 The shared package (Parametros) SHALL hold STACK_ADDRESS, DATA_ADDRESS and the register indices SPR=2 and GPR=3.
REQ-034 The write-merge and bypass mux SHALL live in one sub-module, regfile_wr_merge, instantiated once per read port.
REQ-035 The register array and scoreboard SHALL live in the top module.

Verification
REQ-036 Reset: assert iRST_N=0 mid-run -> x2=STACK_ADDRESS, x3=DATA_ADDRESS, others 0, oRdBusy=0.
REQ-037 Write collision: port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle -> x5=0x22222222 after the edge.
REQ-038 Zero register: write x0=0xFFFFFFFF with iRsvAddr=0 -> x0 reads 0, oRdBusy=0.
REQ-039 Bypass: read x7 during a write of 0xA5A5A5A5 -> oRdData=0xA5A5A5A5 with REGFILE_BYPASS_EN defined, old value without it.
REQ-040 Scoreboard: reserve x9, then write x9 and reserve x9 in the same cycle -> busy stays 1; a later write alone -> busy 0; iFlush with iRsvEn -> all 0.
REQ-041 Parameters: XLEN=64, NREG=16, NRD=3, NWR=1 -> all three ports read correctly and x2 reset is zero-extended.
